// File: rtl/avalon_mm_arbiter_if.sv
// AvalonMmRw: pipelined-read Avalon-MM bundle shared by hosts and agents.
// Host drives the command phase; Agent drives waitrequest and read responses.
interface AvalonMmRw #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   host_to_agent;
    logic [DATA_W-1:0]   agent_to_host;
    logic                read;
    logic                write;
    logic                waitrequest;
    logic                readdatavalid;

    modport Host (
        output address,
        output byteenable,
        output host_to_agent,
        output read,
        output write,
        input  waitrequest,
        input  agent_to_host,
        input  readdatavalid
    );

    modport Agent (
        input  address,
        input  byteenable,
        input  host_to_agent,
        input  read,
        input  write,
        output waitrequest,
        output agent_to_host,
        output readdatavalid
    );
endinterface

// File: rtl/avalon_mm_arbiter.sv
// Two-host Avalon-MM arbiter with an in-order read-owner tracker.
// Define ARB_FIXED_PRIORITY_EN for fixed host0 priority instead of round-robin.
module avalon_mm_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic      clk,
    input  logic      reset,
    AvalonMmRw.Agent  host0,
    AvalonMmRw.Agent  host1,
    AvalonMmRw.Host   mem,
    output logic      protocol_error
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ?
                        $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_H0,
        OWN_H1
    } owner_t;

    owner_t                     r_owner;
`ifndef ARB_FIXED_PRIORITY_EN
    logic                       r_last;
`endif
    logic [MAX_OUTSTANDING-1:0] r_fifo;
    logic [PW-1:0]              r_wp;
    logic [PW-1:0]              r_rp;
    logic [CW-1:0]              r_count;
    logic                       r_perr;

    logic w_req0;
    logic w_req1;
    logic w_gnt;
    logic w_id;
    logic w_s_read;
    logic w_s_write;
    logic w_s_rd;
    logic w_full;
    logic w_empty;
    logic w_rd_blk;
    logic w_hwait;
    logic w_acc;
    logic w_push;
    logic w_pop;
    logic w_head;
    logic w_drop;
    logic w_rw_err;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_req0 = host0.read | host0.write;
    assign w_req1 = host1.read | host1.write;

    // A locked owner keeps the grant; a fresh tie is resolved here.
    always_comb begin
        w_gnt = 1'b0;
        w_id  = 1'b0;
        unique case (r_owner)
            OWN_H0: begin
                w_gnt = w_req0;
                w_id  = 1'b0;
            end
            OWN_H1: begin
                w_gnt = w_req1;
                w_id  = 1'b1;
            end
            default: begin
                w_gnt = w_req0 | w_req1;
                if (w_req0 && w_req1) begin
`ifdef ARB_FIXED_PRIORITY_EN
                    w_id = 1'b0;
`else
                    w_id = ~r_last;
`endif
                end else begin
                    w_id = w_req1;
                end
            end
        endcase
        if (reset) begin
            w_gnt = 1'b0;
        end
    end

    assign w_s_read  = w_id ? host1.read  : host0.read;
    assign w_s_write = w_id ? host1.write : host0.write;
    assign w_s_rd    = w_s_read & ~w_s_write;

    assign w_full   = (r_count == CW'(MAX_OUTSTANDING));
    assign w_empty  = (r_count == '0);
    assign w_rd_blk = w_s_rd & w_full;

    assign mem.read  = w_gnt & w_s_rd & ~w_full;
    assign mem.write = w_gnt & w_s_write;

    assign mem.address = !w_gnt ? '0 :
                         w_id   ? host1.address : host0.address;
    assign mem.byteenable = !w_gnt ? '0 :
                            w_id   ? host1.byteenable : host0.byteenable;
    assign mem.host_to_agent = !w_gnt ? '0 :
                               w_id   ? host1.host_to_agent :
                                        host0.host_to_agent;

    assign w_hwait = mem.waitrequest | w_rd_blk;
    assign host0.waitrequest = ~(w_gnt & ~w_id) | w_hwait;
    assign host1.waitrequest = ~(w_gnt &  w_id) | w_hwait;

    assign w_acc  = (mem.read | mem.write) & ~mem.waitrequest;
    assign w_push = mem.read & ~mem.waitrequest;
    assign w_pop  = mem.readdatavalid & ~w_empty & ~reset;
    assign w_drop = mem.readdatavalid & w_empty;
    assign w_head = r_fifo[r_rp];

    assign w_rw_err = (host0.read & host0.write) |
                      (host1.read & host1.write);

    assign host0.agent_to_host = mem.agent_to_host;
    assign host1.agent_to_host = mem.agent_to_host;
    assign host0.readdatavalid = w_pop & ~w_head;
    assign host1.readdatavalid = w_pop &  w_head;

    assign protocol_error = r_perr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= OWN_NONE;
`ifndef ARB_FIXED_PRIORITY_EN
            r_last  <= 1'b1;
`endif
        end else if (!w_gnt) begin
            r_owner <= OWN_NONE;
        end else if (w_acc) begin
            r_owner <= OWN_NONE;
`ifndef ARB_FIXED_PRIORITY_EN
            r_last  <= w_id;
`endif
        end else begin
            r_owner <= w_id ? OWN_H1 : OWN_H0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fifo  <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_perr  <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wp] <= w_id;
                r_wp         <= f_next(r_wp);
            end
            if (w_pop) begin
                r_rp <= f_next(r_rp);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_rw_err || w_drop) begin
                r_perr <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Scoreboard bench for avalon_mm_arbiter: directed commands and responses.
// Expected commands/responses are queued by stimulus and checked by a monitor.
module tb_avalon_mm_arbiter;
    logic clk;
    logic reset;
    logic protocol_error;

    AvalonMmRw h0_if ();
    AvalonMmRw h1_if ();
    AvalonMmRw mem_if ();

    avalon_mm_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .host0          (h0_if),
        .host1          (h1_if),
        .mem            (mem_if),
        .protocol_error (protocol_error)
    );

    typedef struct {
        bit          id;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } cmd_t;

    typedef struct {
        bit          id;
        logic [31:0] d;
    } rsp_t;

    cmd_t cq[$];
    rsp_t rq[$];
    cmd_t mc;
    rsp_t mr;
    int   n_chk;
    int   n_fail;
    logic mid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int h, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
        if (h == 0) begin
            h0_if.read          = rd;
            h0_if.write         = wr;
            h0_if.address       = a;
            h0_if.host_to_agent = d;
            h0_if.byteenable    = 4'hF;
        end else begin
            h1_if.read          = rd;
            h1_if.write         = wr;
            h1_if.address       = a;
            h1_if.host_to_agent = d;
            h1_if.byteenable    = 4'h3;
        end
    endtask

    task automatic exp_cmd(input bit id, input bit wr,
                           input logic [31:0] a, input logic [31:0] d);
        cmd_t c;
        c.id = id;
        c.wr = wr;
        c.a  = a;
        c.d  = d;
        c.be = id ? 4'h3 : 4'hF;
        cq.push_back(c);
    endtask

    task automatic rsp(input bit id, input logic [31:0] d);
        rsp_t r;
        r.id = id;
        r.d  = d;
        rq.push_back(r);
        mem_if.readdatavalid = 1'b1;
        mem_if.agent_to_host = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if ((mem_if.read | mem_if.write) && !mem_if.waitrequest) begin
                mid = h0_if.waitrequest;
                chk("cmd_onehot", h0_if.waitrequest ^ h1_if.waitrequest, 1);
                if (cq.size() == 0) begin
                    chk("cmd_unexpected", cq.size(), 1);
                end else begin
                    mc = cq.pop_front();
                    chk("cmd_host", mid, mc.id);
                    chk("cmd_write", mem_if.write, mc.wr);
                    chk("cmd_read", mem_if.read, !mc.wr);
                    chk("cmd_addr", mem_if.address, mc.a);
                    chk("cmd_be", mem_if.byteenable, mc.be);
                    if (mc.wr) begin
                        chk("cmd_data", mem_if.host_to_agent, mc.d);
                    end
                end
            end
            if (mem_if.readdatavalid) begin
                if (rq.size() > 0) begin
                    mr = rq.pop_front();
                    chk("rsp_h0_valid", h0_if.readdatavalid, !mr.id);
                    chk("rsp_h1_valid", h1_if.readdatavalid, mr.id);
                    chk("rsp_data", mr.id ? h1_if.agent_to_host :
                                            h0_if.agent_to_host, mr.d);
                end else begin
                    chk("drop_h0_valid", h0_if.readdatavalid, 0);
                    chk("drop_h1_valid", h1_if.readdatavalid, 0);
                end
            end else if (h0_if.readdatavalid | h1_if.readdatavalid) begin
                chk("stray_valid",
                    {h0_if.readdatavalid, h1_if.readdatavalid}, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        mem_if.waitrequest   = 1'b0;
        mem_if.readdatavalid = 1'b0;
        mem_if.agent_to_host = '0;
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mem_read", mem_if.read, 0);
        chk("rst_mem_write", mem_if.write, 0);
        chk("rst_h0_wait", h0_if.waitrequest, 1);
        chk("rst_h1_wait", h1_if.waitrequest, 1);
        chk("rst_h0_rdv", h0_if.readdatavalid, 0);
        chk("rst_h1_rdv", h1_if.readdatavalid, 0);
        chk("rst_perr", protocol_error, 0);
        cyc();
        reset = 1'b0;

        // single read
        cyc();
        drv(0, 1, 0, 32'h100, 0);
        exp_cmd(0, 0, 32'h100, 0);
        #1 chk("single_mem_read", mem_if.read, 1);
        cyc();
        drv(0, 0, 0, 0, 0);
        cyc();
        rsp(0, 32'hDEADBEEF);
        cyc();
        mem_if.readdatavalid = 1'b0;

        // contention from reset
        do_reset();
        drv(0, 0, 1, 32'h200, 32'hA0);
        drv(1, 0, 1, 32'h300, 32'hB1);
`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < 4; i++) exp_cmd(0, 1, 32'h200, 32'hA0);
`else
        for (int i = 0; i < 2; i++) begin
            exp_cmd(0, 1, 32'h200, 32'hA0);
            exp_cmd(1, 1, 32'h300, 32'hB1);
        end
`endif
        repeat (4) cyc();
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);

        // lock while stalled
        cyc();
        drv(1, 0, 1, 32'h500, 32'h55);
        mem_if.waitrequest = 1'b1;
        exp_cmd(1, 1, 32'h500, 32'h55);
        exp_cmd(0, 1, 32'h400, 32'h44);
        #1;
        chk("lock_c1_addr", mem_if.address, 32'h500);
        chk("lock_c1_write", mem_if.write, 1);
        chk("lock_c1_h1_wait", h1_if.waitrequest, 1);
        cyc();
        drv(0, 0, 1, 32'h400, 32'h44);
        #1;
        chk("lock_c2_addr", mem_if.address, 32'h500);
        chk("lock_c2_h0_wait", h0_if.waitrequest, 1);
        cyc();
        chk("lock_c3_addr", mem_if.address, 32'h500);
        chk("lock_c3_data", mem_if.host_to_agent, 32'h55);
        chk("lock_c3_h0_wait", h0_if.waitrequest, 1);
        cyc();
        mem_if.waitrequest = 1'b0;
        #1;
        chk("lock_c4_addr", mem_if.address, 32'h500);
        chk("lock_c4_h1_wait", h1_if.waitrequest, 0);
        chk("lock_c4_h0_wait", h0_if.waitrequest, 1);
        cyc();
        drv(1, 0, 0, 0, 0);
        #1;
        chk("lock_c5_addr", mem_if.address, 32'h400);
        chk("lock_c5_h0_wait", h0_if.waitrequest, 0);
        cyc();
        drv(0, 0, 0, 0, 0);

        // interleaved reads
        cyc();
        drv(0, 1, 0, 32'h10, 0);
        exp_cmd(0, 0, 32'h10, 0);
        cyc();
        drv(0, 0, 0, 0, 0);
        drv(1, 1, 0, 32'h20, 0);
        exp_cmd(1, 0, 32'h20, 0);
        cyc();
        drv(1, 0, 0, 0, 0);
        drv(0, 1, 0, 32'h30, 0);
        exp_cmd(0, 0, 32'h30, 0);
        cyc();
        drv(0, 0, 0, 0, 0);
        cyc();
        rsp(0, 32'h1);
        cyc();
        mem_if.readdatavalid = 1'b0;
        cyc();
        rsp(1, 32'h2);
        cyc();
        mem_if.readdatavalid = 1'b0;
        cyc();
        cyc();
        rsp(0, 32'h3);
        cyc();
        mem_if.readdatavalid = 1'b0;

        // tracker full
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv(0, 1, 0, 32'h1000 + 32'(4 * i), 0);
            exp_cmd(0, 0, 32'h1000 + 32'(4 * i), 0);
            cyc();
        end
        drv(0, 1, 0, 32'h1010, 0);
        drv(1, 0, 1, 32'h600, 32'h66);
`ifndef ARB_FIXED_PRIORITY_EN
        exp_cmd(1, 1, 32'h600, 32'h66);
`endif
        #1;
        chk("full_c5_read", mem_if.read, 0);
        chk("full_c5_h0_wait", h0_if.waitrequest, 1);
        cyc();
`ifndef ARB_FIXED_PRIORITY_EN
        drv(1, 0, 0, 0, 0);
`endif
        #1;
        chk("full_c6_read", mem_if.read, 0);
        chk("full_c6_h0_wait", h0_if.waitrequest, 1);
        cyc();
        chk("full_c7_read", mem_if.read, 0);
        cyc();
        rsp(0, 32'h11);
        #1;
        chk("full_pop_read", mem_if.read, 0);
        chk("full_pop_h0_wait", h0_if.waitrequest, 1);
        cyc();
        mem_if.readdatavalid = 1'b0;
        exp_cmd(0, 0, 32'h1010, 0);
        #1;
        chk("full_issue_read", mem_if.read, 1);
        chk("full_issue_h0_wait", h0_if.waitrequest, 0);
        cyc();
        drv(0, 0, 0, 0, 0);
`ifdef ARB_FIXED_PRIORITY_EN
        exp_cmd(1, 1, 32'h600, 32'h66);
`endif
        cyc();
        drv(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            rsp(0, 32'h12 + 32'(i));
        end
        cyc();
        mem_if.readdatavalid = 1'b0;

        // response with empty tracker
        chk("perr_before_drop", protocol_error, 0);
        cyc();
        mem_if.readdatavalid = 1'b1;
        mem_if.agent_to_host = 32'h77;
        cyc();
        mem_if.readdatavalid = 1'b0;
        #1 chk("perr_after_drop", protocol_error, 1);

        // reset with reads outstanding
        cyc();
        drv(0, 1, 0, 32'h2000, 0);
        exp_cmd(0, 0, 32'h2000, 0);
        cyc();
        drv(0, 1, 0, 32'h2004, 0);
        exp_cmd(0, 0, 32'h2004, 0);
        cyc();
        drv(0, 1, 0, 32'h2008, 0);
        #1 chk("pre_rst_count", dut.r_count, 2);
        #1;
        reset = 1'b1;
        mem_if.readdatavalid = 1'b1;
        #1;
        chk("mid_rst_count", dut.r_count, 0);
        chk("mid_rst_perr", protocol_error, 0);
        chk("mid_rst_mem_read", mem_if.read, 0);
        chk("mid_rst_mem_write", mem_if.write, 0);
        chk("mid_rst_h0_wait", h0_if.waitrequest, 1);
        chk("mid_rst_h1_wait", h1_if.waitrequest, 1);
        chk("mid_rst_h0_rdv", h0_if.readdatavalid, 0);
        chk("mid_rst_h1_rdv", h1_if.readdatavalid, 0);
        cyc();
        drv(0, 0, 0, 0, 0);
        mem_if.readdatavalid = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        chk("post_rst_count", dut.r_count, 0);
        chk("post_rst_perr", protocol_error, 0);
        cyc();

        chk("cmdq_empty", cq.size(), 0);
        chk("rspq_empty", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
